alu_op_sequencer: RTL and testbench

//  Parametrised control-step sequencer for the data_path ALU. Given an opcode, two

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/reg_onehot_dec.sv | 17 +
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared state encoding, opcodes and opcode classifiers for alu_op_sequencer.
// ALU_SEQ_HI_WB_EN (in the top) enables the Z-high writeback step.
package alu_seq_pkg;
  localparam int OPC_W = 5;

  typedef enum logic [3:0] {
    IDLE,
    LD_A_MDR,
    LD_A_Y,
    LD_B_MDR,
    LD_B_REG,
    EXEC,
    ZLO_WB,
    ZHI_WB,
    DONE
  } state_t;

  localparam logic [OPC_W-1:0] OP_NEG = 5'b01001;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;

  function automatic logic is_unary(
    input logic [OPC_W-1:0] op
  );
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_wide(
    input logic [OPC_W-1:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction
endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot enable decoder.
// Indices >= NREG decode to all-zero.
module reg_onehot_dec #(
  parameter int NREG  = 16,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  oh
);
  always_comb begin
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && (idx == IDX_W'(i))) oh[i] = 1'b1;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer driving data_path strobes for one ALU op.
// Define ALU_SEQ_HI_WB_EN to write Z high back for wide ops.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 16,
  parameter  int OP_W   = 5,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              start,
  input  logic [OP_W-1:0]   op_in,
  input  logic [DATA_W-1:0] opa_in,
  input  logic [DATA_W-1:0] opb_in,
  input  logic [IDX_W-1:0]  src_idx,
  input  logic [IDX_W-1:0]  dlo_idx,
  input  logic [IDX_W-1:0]  dhi_idx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              Yin,
  output logic              Zhighin,
  output logic              Zlowin,
  output logic              Zhighout,
  output logic              Zlowout,
  output logic [OP_W-1:0]   op,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout
);
  state_t state, nxt;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] mdata_q, mdata_nx;
  logic [IDX_W-1:0]  src_q, dlo_q, dhi_q;
  logic [IDX_W-1:0]  rin_idx;
  logic              rin_en;
  logic              take;

  assign take = (state == IDLE) && start;

  // Mdatain is registered so it lands together with the MDR load state
  always_comb begin
    nxt      = state;
    mdata_nx = mdata_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (is_unary(OPC_W'(op_in))) begin
            nxt      = LD_B_MDR;
            mdata_nx = opb_in;
          end else begin
            nxt      = LD_A_MDR;
            mdata_nx = opa_in;
          end
        end
      end
      LD_A_MDR: nxt = LD_A_Y;
      LD_A_Y: begin
        nxt      = LD_B_MDR;
        mdata_nx = opb_q;
      end
      LD_B_MDR: nxt = LD_B_REG;
      LD_B_REG: nxt = EXEC;
      EXEC:     nxt = ZLO_WB;
      ZLO_WB: begin
        nxt = DONE;
`ifdef ALU_SEQ_HI_WB_EN
        if (is_wide(OPC_W'(op_q))) nxt = ZHI_WB;
`endif
      end
      ZHI_WB:   nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state   <= IDLE;
      mdata_q <= '0;
      op_q    <= '0;
      opb_q   <= '0;
      src_q   <= '0;
      dlo_q   <= '0;
      dhi_q   <= '0;
    end else begin
      state   <= nxt;
      mdata_q <= mdata_nx;
      if (take) begin
        op_q  <= op_in;
        opb_q <= opb_in;
        src_q <= src_idx;
        dlo_q <= dlo_idx;
        dhi_q <= dhi_idx;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign Mdatain = mdata_q;
  assign op      = busy ? op_q : '0;
  assign Read    = (state == LD_A_MDR) || (state == LD_B_MDR);
  assign MDRin   = Read;
  assign MDRout  = (state == LD_A_Y) || (state == LD_B_REG);
  assign Yin     = (state == LD_A_Y);
  assign Zhighin = (state == EXEC);
  assign Zlowin  = (state == EXEC);
  assign Zlowout = (state == ZLO_WB);
`ifdef ALU_SEQ_HI_WB_EN
  assign Zhighout = (state == ZHI_WB);
`else
  assign Zhighout = 1'b0;
`endif

  always_comb begin
    rin_en  = 1'b0;
    rin_idx = '0;
    unique case (1'b1)
      (state == LD_B_REG): begin
        rin_en  = 1'b1;
        rin_idx = src_q;
      end
      (state == ZLO_WB): begin
        rin_en  = 1'b1;
        rin_idx = dlo_q;
      end
      (state == ZHI_WB): begin
        rin_en  = 1'b1;
        rin_idx = dhi_q;
      end
      default: ;
    endcase
  end

  reg_onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_rin (
    .idx (rin_idx),
    .en  (rin_en),
    .oh  (Rin)
  );

  reg_onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_rout (
    .idx (src_q),
    .en  (state == EXEC),
    .oh  (Rout)
  );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer.
// Expected step schedules are built per request from the op class.
module tb_alu_op_sequencer;
  localparam int NREG = 12;

  logic        Clock = 0;
  logic        clear = 0;
  logic        start = 0;
  logic [4:0]  op_in = 0;
  logic [31:0] opa_in = 0, opb_in = 0;
  logic [3:0]  src_idx = 0, dlo_idx = 0, dhi_idx = 0;
  logic        busy, done, Read, MDRin, MDRout, Yin;
  logic        Zhighin, Zlowin, Zhighout, Zlowout;
  logic [31:0] Mdatain;
  logic [4:0]  op;
  logic [NREG-1:0] Rin, Rout;

  int checks = 0;
  int errors = 0;

`ifdef ALU_SEQ_HI_WB_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  alu_op_sequencer #(.DATA_W(32), .NREG(NREG), .OP_W(5)) dut (
    .Clock(Clock), .clear(clear), .start(start), .op_in(op_in),
    .opa_in(opa_in), .opb_in(opb_in), .src_idx(src_idx),
    .dlo_idx(dlo_idx), .dhi_idx(dhi_idx), .busy(busy), .done(done),
    .Mdatain(Mdatain), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .op(op),
    .Rin(Rin), .Rout(Rout)
  );

  always #5 Clock = ~Clock;

  typedef enum {K_MDR, K_Y, K_REG, K_EXEC, K_ZLO, K_ZHI, K_DONE} kind_t;
  typedef struct {
    kind_t       k;
    logic [3:0]  idx;
    logic [31:0] md;
  } step_t;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [NREG-1:0] oh(input logic [3:0] i);
    logic [NREG-1:0] v = '0;
    if (int'(i) < NREG) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [9:0] strobes_now();
    return {busy, done, Read, MDRin, MDRout, Yin,
            Zhighin, Zlowin, Zhighout, Zlowout};
  endfunction

  task automatic check_step(input string tag, input step_t s,
                            input logic [4:0] o);
    logic [9:0]      es;
    logic [NREG-1:0] er, eo;
    er = '0;
    eo = '0;
    case (s.k)
      K_MDR:  es = 10'b10_1100_0000;
      K_Y:    es = 10'b10_0011_0000;
      K_REG:  begin es = 10'b10_0010_0000; er = oh(s.idx); end
      K_EXEC: begin es = 10'b10_0000_1100; eo = oh(s.idx); end
      K_ZLO:  begin es = 10'b10_0000_0001; er = oh(s.idx); end
      K_ZHI:  begin es = 10'b10_0000_0010; er = oh(s.idx); end
      default: es = 10'b11_0000_0000;
    endcase
    check({tag, ".strb"}, 64'(strobes_now()), 64'(es));
    check({tag, ".rin"},  64'(Rin),  64'(er));
    check({tag, ".rout"}, 64'(Rout), 64'(eo));
    check({tag, ".md"},   64'(Mdatain), 64'(s.md));
    check({tag, ".op"},   64'(op), 64'(o));
  endtask

  task automatic check_idle(input string tag, input logic [31:0] md);
    check({tag, ".strb"}, 64'(strobes_now()), 64'd0);
    check({tag, ".rin"},  64'(Rin), 64'd0);
    check({tag, ".rout"}, 64'(Rout), 64'd0);
    check({tag, ".op"},   64'(op), 64'd0);
    check({tag, ".md"},   64'(Mdatain), 64'(md));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run_req(input string tag, input logic [4:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, input logic [3:0] l,
                         input logic [3:0] h, input bit hold);
    step_t q[$];
    bit    un, wd;
    int    lat, seen;
    un = (o == 5'b01001) || (o == 5'b01010);
    wd = (o == 5'b01111) || (o == 5'b10000);
    if (!un) begin
      q.push_back('{K_MDR, 4'd0, a});
      q.push_back('{K_Y, 4'd0, a});
    end
    q.push_back('{K_MDR, 4'd0, b});
    q.push_back('{K_REG, s, b});
    q.push_back('{K_EXEC, s, b});
    q.push_back('{K_ZLO, l, b});
    if (wd && HI_EN) q.push_back('{K_ZHI, h, b});
    q.push_back('{K_DONE, 4'd0, b});
    lat = (un ? 5 : 7) + ((wd && HI_EN) ? 1 : 0);
    seen = -1;
    start = 1; op_in = o; opa_in = a; opb_in = b;
    src_idx = s; dlo_idx = l; dhi_idx = h;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge Clock);
      if (!hold) start = 0;
      op_in = 5'($urandom); opa_in = $urandom; opb_in = $urandom;
      src_idx = 4'($urandom); dlo_idx = 4'($urandom);
      dhi_idx = 4'($urandom);
      if (done && seen < 0) seen = i + 1;
      check_step($sformatf("%s.c%0d", tag, i + 1), q[i], o);
    end
    check({tag, ".lat"}, 64'(seen), 64'(lat));
    @(negedge Clock);
    check_idle({tag, ".idle"}, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    clear = 0;
    repeat (2) @(negedge Clock);
    check_idle("reset", 32'd0);
    clear = 1;
    @(negedge Clock);
    check_idle("post_reset", 32'd0);

    run_req("add", 5'b00011, 32'd12, 32'd5, 4'd2, 4'd1, 4'd3, 0);
    run_req("neg", 5'b01001, 32'd99, 32'd5, 4'd2, 4'd1, 4'd3, 0);
    run_req("mul", 5'b01111, 32'd7, 32'd6, 4'd2, 4'd1, 4'd0, 0);
    run_req("div", 5'b10000, 32'd8, 32'd2, 4'd3, 4'd3, 4'd3, 0);
    run_req("oor", 5'b00100, 32'd1, 32'd2, 4'd13, 4'd15, 4'd12, 0);
    run_req("hold1", 5'b00101, 32'd3, 32'd4, 4'd5, 4'd6, 4'd7, 1);
    run_req("hold2", 5'b01010, 32'd9, 32'd8, 4'd1, 4'd0, 4'd2, 0);

    start = 1; op_in = 5'b00011; opa_in = 32'd12; opb_in = 32'd5;
    src_idx = 4'd2; dlo_idx = 4'd1; dhi_idx = 4'd0;
    repeat (5) begin
      @(negedge Clock);
      start = 0;
    end
    check("abort.exec", 64'(Zlowin), 64'd1);
    clear = 0;
    @(negedge Clock);
    check_idle("abort", 32'd0);
    clear = 1;
    @(negedge Clock);
    check_idle("abort_rel", 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] o;
      case ($urandom_range(0, 5))
        0: o = 5'b01001;
        1: o = 5'b01010;
        2: o = 5'b01111;
        3: o = 5'b10000;
        default: o = 5'($urandom);
      endcase
      run_req($sformatf("rnd%0d", n), o, $urandom, $urandom,
              4'($urandom), 4'($urandom), 4'($urandom),
              bit'($urandom_range(0, 1)));
    end
    start = 0;
    @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
